// File: rtl/ta_train_ctrl_pkg.sv
// rtl/ta_train_ctrl_pkg.sv - shared types and constants for the Tsetlin clause trainer
package ta_train_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_FEED = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int N_FEAT_DEF  = 4;
    localparam int ST_BITS_DEF = 3;

    function automatic int ta_reset_val(input int st_bits);
        return (2 ** (st_bits - 1)) - 1;
    endfunction

    function automatic int ta_max(input int st_bits);
        return (2 ** st_bits) - 1;
    endfunction

    function automatic int n_lit(input int n_feat);
        return 2 * n_feat;
    endfunction

    // Negated literal of feature i sits N_FEAT positions above the plain one.
    function automatic int lit_neg_idx(input int i, input int n_feat);
        return i + n_feat;
    endfunction

    localparam int TA_RESET_VAL = ta_reset_val(ST_BITS_DEF);
    localparam int TA_MAX       = ta_max(ST_BITS_DEF);

endpackage

// File: rtl/ta_train_ctrl_counter.sv
// rtl/ta_train_ctrl_counter.sv - saturating Tsetlin automaton state counter
module ta_counter
    import ta_train_ctrl_pkg::*;
#(
    parameter int ST_BITS = ST_BITS_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [ST_BITS-1:0] o_state
);

    localparam logic [ST_BITS-1:0] RST_VAL = ST_BITS'(ta_reset_val(ST_BITS));
    localparam logic [ST_BITS-1:0] MAX_VAL = ST_BITS'(ta_max(ST_BITS));

    logic [ST_BITS-1:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RST_VAL;
        end else if (i_inc && !i_dec && (r_state != MAX_VAL)) begin
            r_state <= r_state + ST_BITS'(1);
        end else if (i_dec && !i_inc && (r_state != '0)) begin
            r_state <= r_state - ST_BITS'(1);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/ta_train_ctrl.sv
// rtl/ta_train_ctrl.sv - one-clause Tsetlin training sequencer (EVAL then per-TA feedback)
module ta_train_ctrl
    import ta_train_ctrl_pkg::*;
#(
    parameter int N_FEAT  = N_FEAT_DEF,
    parameter int ST_BITS = ST_BITS_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [N_FEAT-1:0]     i_x,
    input  logic                  i_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_clause_out,
    output logic [2*N_FEAT-1:0]   o_include
);

    localparam int N_LIT  = n_lit(N_FEAT);
    localparam int K_BITS = $clog2(N_LIT);
    localparam logic [K_BITS-1:0] K_LAST = K_BITS'(N_LIT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [N_FEAT-1:0]   r_x;
    logic                r_y;
    logic                r_clause;
    logic [K_BITS-1:0]   r_k;

    logic [N_LIT-1:0]    w_lit;
    logic [N_LIT-1:0]    w_include;
    logic [N_LIT-1:0]    w_inc;
    logic [N_LIT-1:0]    w_dec;
    logic                w_clause_eval;
    logic                w_inc_k;
    logic                w_dec_k;
    logic [ST_BITS-1:0]  w_ta_state [N_LIT];

    assign w_lit         = {~r_x, r_x};
    // A literal only constrains the clause when its TA includes it.
    assign w_clause_eval = &(w_lit | ~w_include);

    for (genvar g = 0; g < N_LIT; g++) begin : g_ta
        ta_counter #(.ST_BITS(ST_BITS)) u_ta (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_inc   (w_inc[g]),
            .i_dec   (w_dec[g]),
            .o_state (w_ta_state[g])
        );
        assign w_include[g] = w_ta_state[g][ST_BITS-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_EVAL;
            ST_EVAL: w_next = ST_FEED;
            ST_FEED: if (r_k == K_LAST) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_inc_k = 1'b0;
        w_dec_k = 1'b0;
        if (r_state == ST_FEED) begin
            if (r_y) begin
                w_inc_k = r_clause && w_lit[r_k];
                w_dec_k = !(r_clause && w_lit[r_k]);
            end else begin
                w_inc_k = r_clause && !w_lit[r_k] && !w_include[r_k];
            end
        end
        w_inc = N_LIT'(w_inc_k) << r_k;
        w_dec = N_LIT'(w_dec_k) << r_k;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x      <= '0;
            r_y      <= 1'b0;
            r_clause <= 1'b0;
            r_k      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_x <= i_x;
                        r_y <= i_y;
                    end
                end
                ST_EVAL: begin
                    r_clause <= w_clause_eval;
                    r_k      <= '0;
                end
                ST_FEED: begin
                    if (r_k != K_LAST) r_k <= r_k + K_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_clause_out = r_clause;
    assign o_include    = w_include;

endmodule

// File: tb/tb_ta_train_ctrl.sv
// tb/tb_ta_train_ctrl.sv - self-checking bench for ta_train_ctrl
module tb_ta_train_ctrl;

    localparam int NF   = 4;
    localparam int NL   = 2 * NF;
    localparam int SMAX = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [NF-1:0] x = '0;
    logic          y = 1'b0;
    logic          busy, done, clause_out;
    logic [NL-1:0] include_v;

    int checks = 0;
    int failures = 0;

    ta_train_ctrl #(.N_FEAT(NF), .ST_BITS(3)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_x          (x),
        .i_y          (y),
        .o_busy       (busy),
        .o_done       (done),
        .o_clause_out (clause_out),
        .o_include    (include_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: m_t is the cycle number within a step (0 = idle,
    // 1 = evaluate, 2..NL+1 = feedback for TA m_t-2, NL+2 = done).
    int            m_cnt [NL];
    int            m_t = 0;
    logic          m_clause = 1'b0;
    logic          m_valid = 1'b0;
    logic [NF-1:0] m_x;
    logic          m_y;

    function automatic logic m_lit(input int j);
        return (j < NF) ? m_x[j] : ~m_x[j-NF];
    endfunction

    function automatic logic [NL-1:0] m_include();
        logic [NL-1:0] v;
        for (int j = 0; j < NL; j++) v[j] = (m_cnt[j] >= 4);
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NL; j++) m_cnt[j] = 3;
            m_t = 0; m_clause = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_t == 0) begin
                if (start) begin m_x = x; m_y = y; m_t = 1; end
            end else if (m_t == 1) begin
                m_clause = 1'b1;
                for (int j = 0; j < NL; j++)
                    if (m_cnt[j] >= 4 && !m_lit(j)) m_clause = 1'b0;
                m_t = 2;
            end else if (m_t <= NL + 1) begin
                int k;
                k = m_t - 2;
                if (m_y) begin
                    if (m_clause && m_lit(k)) m_cnt[k] = (m_cnt[k] < SMAX) ? m_cnt[k] + 1 : SMAX;
                    else                      m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
                end else if (m_clause && !m_lit(k) && m_cnt[k] < 4) begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                m_t = m_t + 1;
            end else begin
                m_t = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_t != 0));
            chk("done", 32'(done), 32'(m_t == NL + 2));
            chk("clause_out", 32'(clause_out), 32'(m_clause));
            chk("include", 32'(include_v), 32'(m_include()));
        end
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic run_step(input logic [NF-1:0] xv, input logic yv, output int lat);
        @(negedge clk); start = 1'b1; x = xv; y = yv;
        @(negedge clk); start = 1'b0; x = ~xv; y = ~yv;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic pin_counts(input string name, input int e0, e1, e2, e3, e4, e5, e6, e7);
        int e [NL];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int j = 0; j < NL; j++) chk(name, 32'(m_cnt[j]), 32'(e[j]));
    endtask

    initial begin
        int lat;
        int dcnt;

        // 1: reset state
        do_reset();
        chk("rst_include", 32'(include_v), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clause", 32'(clause_out), 32'd0);
        pin_counts("rst_cnt", 3, 3, 3, 3, 3, 3, 3, 3);

        // 2: first Type I step from empty clause
        run_step(4'b0101, 1'b1, lat);
        chk("s2_latency", 32'(lat), 32'd10);
        chk("s2_clause", 32'(clause_out), 32'd1);
        chk("s2_include", 32'(include_v), 32'hA5);
        pin_counts("s2_cnt", 4, 2, 4, 2, 2, 4, 2, 4);

        // 5: Type II with a sample that falsifies the clause
        run_step(4'b1111, 1'b0, lat);
        chk("s5_clause", 32'(clause_out), 32'd0);
        chk("s5_include", 32'(include_v), 32'hA5);
        pin_counts("s5_cnt", 4, 2, 4, 2, 2, 4, 2, 4);

        // 3: repeated Type I steps saturate both directions
        for (int s = 0; s < 5; s++) begin
            run_step(4'b0101, 1'b1, lat);
            chk("s3_clause", 32'(clause_out), 32'd1);
            chk("s3_include", 32'(include_v), 32'hA5);
        end
        pin_counts("s3_cnt", 7, 0, 7, 0, 0, 7, 0, 7);

        // 4: Type II from reset
        do_reset();
        run_step(4'b0000, 1'b0, lat);
        chk("s4_clause", 32'(clause_out), 32'd1);
        chk("s4_include", 32'(include_v), 32'h0F);
        pin_counts("s4_cnt", 4, 4, 4, 4, 3, 3, 3, 3);

        // 6a: start mid-step and start during DONE are both ignored
        @(negedge clk); start = 1'b1; x = 4'b0011; y = 1'b1;
        @(negedge clk); start = 1'b0;
        dcnt = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3)  start = 1'b1;
            if (n == 4)  start = 1'b0;
            if (n == 10) begin chk("s6_done_at10", 32'(done), 32'd1); start = 1'b1; end
            if (n == 11) begin start = 1'b0; chk("s6_idle_after_done", 32'(busy), 32'd0); end
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("s6_done_pulses", 32'(dcnt), 32'd1);

        // 6b: reset during feedback at k=3 discards the step
        @(negedge clk); start = 1'b1; x = 4'b1010; y = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n < 5; n++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_include", 32'(include_v), 32'h00);
        pin_counts("s6_rst_cnt", 3, 3, 3, 3, 3, 3, 3, 3);
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("s6_rst_no_done", 32'(dcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
